// File: rtl/rdw_pkg.sv
// Shared types and helpers for the read-data-wait queue between MEM and WB.
package rdw_pkg;

   // Per-entry completion flags; data and payload widths are fixed by the top's parameters.
   typedef struct packed {
      logic need_resp;
      logic has_data;
   } rdw_flags_t;

   // Counter width that can hold MAX_OUT plus one in-flight push without wrapping.
   function automatic int rdw_cnt_w(input int max_out);
      return $clog2(max_out + 2);
   endfunction

endpackage

// File: rtl/rdw_resp_tracker.sv
// Tracks responses owed by queued and flushed instructions and picks
// which queued entry the next data_ok belongs to.
module rdw_resp_tracker
   import rdw_pkg::*;
#(
   parameter int DEPTH   = 4,
   parameter int MAX_OUT = 4,
   parameter int CNT_W   = rdw_cnt_w(MAX_OUT),
   parameter int AW      = $clog2(DEPTH)
)(
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             data_ok,
   input  logic             push_owes,
   input  logic [AW:0]      count,
   input  logic [AW-1:0]    rd_ptr,
   input  logic [DEPTH-1:0] pend_vec,
   output logic             route,
   output logic [AW-1:0]    tgt_idx,
   output logic             req_allow,
   output logic [CNT_W-1:0] pending_cnt,
   output logic [CNT_W-1:0] discard_cnt,
   output logic             resp_err
);

   localparam int SW = CNT_W + 2;
   localparam logic [SW-1:0] SAT = {2'b00, {CNT_W{1'b1}}};

   logic [CNT_W-1:0] pending_q, pending_d;
   logic [CNT_W-1:0] discard_q, discard_d;
   logic             resp_err_q, resp_err_d;

   logic             found;
   logic             owed;
   logic [AW-1:0]    idx;
   logic [SW-1:0]    pend_sum;
   logic [SW-1:0]    disc_sum;

   // Oldest-pending pointer: first still-waiting entry walking from the head.
   always_comb begin
      found   = 1'b0;
      tgt_idx = rd_ptr;
      idx     = rd_ptr;
      for (int i = 0; i < DEPTH; i++) begin
         idx = rd_ptr + AW'(i);
         if (!found && ((AW+1)'(i) < count) && pend_vec[idx]) begin
            found   = 1'b1;
            tgt_idx = idx;
         end
      end
   end

   assign owed  = (pending_q != '0) || (discard_q != '0);
   assign route = data_ok && !flush && (discard_q == '0) && (pending_q != '0) && found;

   always_comb begin
      pend_sum   = {2'b00, pending_q} + SW'(push_owes) - SW'(route);
      disc_sum   = {2'b00, discard_q};
      resp_err_d = resp_err_q;
      if (flush) begin
         pend_sum = '0;
         disc_sum = {2'b00, discard_q} + {2'b00, pending_q} + SW'(push_owes)
                    - SW'(data_ok && owed);
         if (data_ok && !owed) resp_err_d = 1'b1;
      end else if (data_ok) begin
         if (discard_q != '0)      disc_sum   = {2'b00, discard_q} - SW'(1);
         else if (pending_q == '0) resp_err_d = 1'b1;
      end
      pending_d = (pend_sum > SAT) ? {CNT_W{1'b1}} : pend_sum[CNT_W-1:0];
      discard_d = (disc_sum > SAT) ? {CNT_W{1'b1}} : disc_sum[CNT_W-1:0];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pending_q  <= '0;
         discard_q  <= '0;
         resp_err_q <= 1'b0;
      end else begin
         pending_q  <= pending_d;
         discard_q  <= discard_d;
         resp_err_q <= resp_err_d;
      end
   end

   assign req_allow   = ({1'b0, pending_q} + {1'b0, discard_q}) < (CNT_W+1)'(MAX_OUT);
   assign pending_cnt = pending_q;
   assign discard_cnt = discard_q;
   assign resp_err    = resp_err_q;

endmodule

// File: rtl/rdw_queue.sv
// In-order queue of MEM instructions awaiting their data_ok; forwards a
// response to WB in the cycle it arrives when it belongs to the head.
module rdw_queue
   import rdw_pkg::*;
#(
   parameter int DATA_W    = 32,
   parameter int PAYLOAD_W = 128,
   parameter int DEPTH     = 4,
   parameter int MAX_OUT   = 4,
   parameter int CNT_W     = rdw_cnt_w(MAX_OUT)
)(
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic                 in_need_resp,
   input  logic                 in_has_data,
   input  logic [DATA_W-1:0]    in_data,
   input  logic [PAYLOAD_W-1:0] in_payload,
   input  logic                 data_ok,
   input  logic [DATA_W-1:0]    rdata,
   input  logic                 flush,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [DATA_W-1:0]    out_data,
   output logic [PAYLOAD_W-1:0] out_payload,
   output logic                 req_allow,
   output logic [CNT_W-1:0]     pending_cnt,
   output logic [CNT_W-1:0]     discard_cnt,
   output logic                 resp_err
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

   typedef struct packed {
      rdw_flags_t           flags;
      logic [DATA_W-1:0]    data;
      logic [PAYLOAD_W-1:0] payload;
   } entry_t;

   entry_t        mem_q [DEPTH];
   entry_t        mem_d [DEPTH];
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW:0]   count_q, count_d;

   logic             empty;
   logic             push, pop, push_owes;
   logic             route, head_tgt, out_valid_c;
   logic [AW-1:0]    tgt_idx;
   logic [DEPTH-1:0] pend_vec;
   entry_t           head;

   // Both ports use strict valid/ready: a transfer happens exactly in a cycle
   // where valid and ready are high together; ready never waits on valid.
   assign empty       = (count_q == '0);
   assign head        = mem_q[rd_ptr_q];
   assign head_tgt    = route && (tgt_idx == rd_ptr_q);
   assign out_valid_c = !flush && !empty && (head.flags.has_data || head_tgt);
   assign pop         = out_valid_c && out_ready;
   assign in_ready    = !rst && ((count_q < DEPTH_C) || pop);
   assign push        = in_valid && in_ready;
   assign push_owes   = push && in_need_resp && !in_has_data;

   always_comb begin
      for (int i = 0; i < DEPTH; i++)
         pend_vec[i] = mem_q[i].flags.need_resp && !mem_q[i].flags.has_data;
   end

   rdw_resp_tracker #(
      .DEPTH   (DEPTH),
      .MAX_OUT (MAX_OUT),
      .CNT_W   (CNT_W),
      .AW      (AW)
   ) u_tracker (
      .clk         (clk),
      .rst         (rst),
      .flush       (flush),
      .data_ok     (data_ok),
      .push_owes   (push_owes),
      .count       (count_q),
      .rd_ptr      (rd_ptr_q),
      .pend_vec    (pend_vec),
      .route       (route),
      .tgt_idx     (tgt_idx),
      .req_allow   (req_allow),
      .pending_cnt (pending_cnt),
      .discard_cnt (discard_cnt),
      .resp_err    (resp_err)
   );

   // A response write lands before the push so a full-queue pop/push on the
   // same slot keeps the newly pushed entry.
   always_comb begin
      mem_d    = mem_q;
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      if (flush) begin
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (route) begin
            mem_d[tgt_idx].data           = rdata;
            mem_d[tgt_idx].flags.has_data = 1'b1;
         end
         if (push) begin
            mem_d[wr_ptr_q].flags.need_resp = in_need_resp;
            mem_d[wr_ptr_q].flags.has_data  = in_has_data || !in_need_resp;
            mem_d[wr_ptr_q].data            = in_has_data ? in_data : '0;
            mem_d[wr_ptr_q].payload         = in_payload;
            wr_ptr_d                        = wr_ptr_q + AW'(1);
         end
         if (pop) rd_ptr_d = rd_ptr_q + AW'(1);
         count_d = count_q + (AW+1)'(push) - (AW+1)'(pop);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         mem_q    <= mem_d;
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
      end
   end

   assign out_valid   = out_valid_c;
   assign out_data    = empty ? '0 : (head_tgt ? rdata : head.data);
   assign out_payload = empty ? '0 : head.payload;

endmodule

// File: tb/tb_rdw_queue.sv
// Directed bench for rdw_queue: hand-computed expectations for each scenario.
module tb_rdw_queue;

   logic         clk = 1'b0;
   logic         rst;
   logic         in_valid, in_ready, in_need_resp, in_has_data;
   logic [31:0]  in_data;
   logic [127:0] in_payload;
   logic         data_ok;
   logic [31:0]  rdata;
   logic         flush;
   logic         out_valid, out_ready;
   logic [31:0]  out_data;
   logic [127:0] out_payload;
   logic         req_allow;
   logic [2:0]   pending_cnt, discard_cnt;
   logic         resp_err;

   int n_cmp = 0;
   int n_err = 0;

   rdw_queue dut (
      .clk          (clk),
      .rst          (rst),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .in_need_resp (in_need_resp),
      .in_has_data  (in_has_data),
      .in_data      (in_data),
      .in_payload   (in_payload),
      .data_ok      (data_ok),
      .rdata        (rdata),
      .flush        (flush),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_data     (out_data),
      .out_payload  (out_payload),
      .req_allow    (req_allow),
      .pending_cnt  (pending_cnt),
      .discard_cnt  (discard_cnt),
      .resp_err     (resp_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Inputs change 1ns after the rising edge; checks run 1ns after that.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      in_valid     = 1'b0;
      in_need_resp = 1'b0;
      in_has_data  = 1'b0;
      in_data      = '0;
      in_payload   = '0;
      data_ok      = 1'b0;
      rdata        = '0;
      flush        = 1'b0;
   endtask

   task automatic drive_push(input logic need, input logic has, input logic [31:0] d,
                             input logic [127:0] pl);
      in_valid     = 1'b1;
      in_need_resp = need;
      in_has_data  = has;
      in_data      = d;
      in_payload   = pl;
   endtask

   task automatic drive_resp(input logic [31:0] d);
      data_ok = 1'b1;
      rdata   = d;
   endtask

   logic [31:0] exp_d [4];

   initial begin
      idle_inputs();
      out_ready = 1'b0;
      rst       = 1'b1;
      #1;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_data", out_data, 0);
      chk("rst_pending", pending_cnt, 0);
      chk("rst_discard", discard_cnt, 0);
      chk("rst_resp_err", resp_err, 0);
      chk("rst_in_ready", in_ready, 0);
      chk("rst_req_allow", req_allow, 1);
      tick();
      rst = 1'b0;
      tick();

      // Single load, response three cycles later, zero-latency forward.
      out_ready = 1'b1;
      drive_push(1, 0, 0, 128'h1);
      #1 chk("t1_in_ready", in_ready, 1);
      tick();
      idle_inputs();
      #1;
      chk("t1_pending_1", pending_cnt, 1);
      chk("t1_wait_valid", out_valid, 0);
      tick();
      tick();
      drive_resp(32'hDEADBEEF);
      #1;
      chk("t1_valid", out_valid, 1);
      chk("t1_data", out_data, 32'hDEADBEEF);
      chk("t1_payload", out_payload, 128'h1);
      tick();
      idle_inputs();
      #1;
      chk("t1_pending_0", pending_cnt, 0);
      chk("t1_empty", out_valid, 0);

      // Four loads fill the queue, responses arrive while WB stalls.
      out_ready = 1'b0;
      exp_d[0] = 32'h11; exp_d[1] = 32'h22; exp_d[2] = 32'h33; exp_d[3] = 32'h44;
      for (int i = 0; i < 4; i++) begin
         drive_push(1, 0, 0, 128'(10 + i));
         tick();
      end
      idle_inputs();
      #1;
      chk("t2_in_ready_full", in_ready, 0);
      chk("t2_req_allow", req_allow, 0);
      chk("t2_pending_4", pending_cnt, 4);
      for (int i = 0; i < 4; i++) begin
         drive_resp(exp_d[i]);
         #1;
         if (i == 0) begin
            chk("t2_head_fwd_valid", out_valid, 1);
            chk("t2_head_fwd_data", out_data, 32'h11);
         end
         tick();
      end
      idle_inputs();
      #1;
      chk("t2_pending_0", pending_cnt, 0);
      chk("t2_req_allow_back", req_allow, 1);
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         #1;
         chk("t2_pop_valid", out_valid, 1);
         chk("t2_pop_data", out_data, exp_d[i]);
         chk("t2_pop_payload", out_payload, 128'(10 + i));
         tick();
      end
      #1 chk("t2_drained", out_valid, 0);

      // Flush with three loads pending and a simultaneous data_ok.
      for (int i = 0; i < 3; i++) begin
         drive_push(1, 0, 0, 128'(16 + i));
         tick();
      end
      idle_inputs();
      flush = 1'b1;
      drive_resp(32'hAA);
      #1 chk("t3_flush_valid", out_valid, 0);
      tick();
      idle_inputs();
      #1;
      chk("t3_discard_2", discard_cnt, 2);
      chk("t3_pending_0", pending_cnt, 0);
      drive_resp(32'h66);
      #1 chk("t3_drop1_valid", out_valid, 0);
      tick();
      drive_resp(32'h77);
      #1 chk("t3_drop2_valid", out_valid, 0);
      tick();
      idle_inputs();
      #1;
      chk("t3_discard_0", discard_cnt, 0);
      chk("t3_no_err", resp_err, 0);
      drive_push(1, 0, 0, 128'h20);
      tick();
      idle_inputs();
      drive_resp(32'h55);
      #1;
      chk("t3_new_valid", out_valid, 1);
      chk("t3_new_data", out_data, 32'h55);
      chk("t3_new_payload", out_payload, 128'h20);
      tick();
      idle_inputs();

      // Load, ALU op, and a load with data already captured, in order.
      drive_push(1, 0, 0, 128'h30);
      tick();
      drive_push(0, 0, 32'hFFFF, 128'h31);
      tick();
      drive_push(1, 1, 32'h1234, 128'h32);
      tick();
      idle_inputs();
      #1 chk("t4_blocked", out_valid, 0);
      tick();
      #1 chk("t4_still_blocked", out_valid, 0);
      chk("t4_pending", pending_cnt, 1);
      drive_resp(32'h99);
      #1;
      chk("t4_load_valid", out_valid, 1);
      chk("t4_load_data", out_data, 32'h99);
      chk("t4_load_payload", out_payload, 128'h30);
      tick();
      idle_inputs();
      #1;
      chk("t4_alu_valid", out_valid, 1);
      chk("t4_alu_data", out_data, 0);
      chk("t4_alu_payload", out_payload, 128'h31);
      tick();
      #1;
      chk("t4_cap_valid", out_valid, 1);
      chk("t4_cap_data", out_data, 32'h1234);
      chk("t4_cap_payload", out_payload, 128'h32);
      tick();
      #1 chk("t4_empty", out_valid, 0);

      // Unowed response sets a sticky error and leaves the queue alone.
      drive_resp(32'hBAD);
      #1 chk("t5_no_valid", out_valid, 0);
      tick();
      idle_inputs();
      #1;
      chk("t5_err", resp_err, 1);
      chk("t5_pending", pending_cnt, 0);
      chk("t5_discard", discard_cnt, 0);
      chk("t5_in_ready", in_ready, 1);
      tick();
      tick();
      #1 chk("t5_err_sticky", resp_err, 1);

      // Asynchronous reset mid-operation.
      out_ready = 1'b0;
      drive_push(1, 0, 0, 128'h40);
      tick();
      drive_push(1, 0, 0, 128'h41);
      tick();
      idle_inputs();
      #1 chk("t6_pending_2", pending_cnt, 2);
      rst = 1'b1;
      #1;
      chk("t6_pending", pending_cnt, 0);
      chk("t6_discard", discard_cnt, 0);
      chk("t6_err", resp_err, 0);
      chk("t6_valid", out_valid, 0);
      chk("t6_data", out_data, 0);
      chk("t6_in_ready", in_ready, 0);
      tick();
      rst = 1'b0;
      drive_resp(32'h77);
      tick();
      idle_inputs();
      #1 chk("t6_post_err", resp_err, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
